// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the adder slave: response codes, register
// offsets, channel FSM states and the byte-strobe merge helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam int OFS_OP_A   = 0;
    localparam int OFS_OP_B   = 4;
    localparam int OFS_RESULT = 8;
    localparam int OFS_STATUS = 12;

    // Widest data path apply_wstrb handles; callers zero-extend in and truncate out.
    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    function automatic logic [MAX_DW-1:0] apply_wstrb(input logic [MAX_DW-1:0] old_v,
                                                      input logic [MAX_DW-1:0] new_v,
                                                      input logic [MAX_SW-1:0] strb);
        logic [MAX_DW-1:0] res;
        res = old_v;
        for (int i = 0; i < MAX_SW; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_adder_slave.sv
// AXI4-Lite slave: two RW operands, RO sum and status. Write response 1 cycle after the
// later of AW/W; read data 1 cycle after AR. Responses are held until bready/rready.
module axi_lite_adder_slave
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);

    typedef enum logic [2:0] {SEL_OP_A, SEL_OP_B, SEL_RESULT, SEL_STATUS, SEL_NONE} sel_e;

    // Borrow out of the subtraction flags addresses below this instance's window.
    function automatic sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE};
        if (diff[ADDR_WIDTH]) return SEL_NONE;
        case (diff[ADDR_WIDTH-1:0])
            ADDR_WIDTH'(OFS_OP_A):   return SEL_OP_A;
            ADDR_WIDTH'(OFS_OP_B):   return SEL_OP_B;
            ADDR_WIDTH'(OFS_RESULT): return SEL_RESULT;
            ADDR_WIDTH'(OFS_STATUS): return SEL_STATUS;
            default:                 return SEL_NONE;
        endcase
    endfunction

    wr_state_e             wstate_q, wstate_d;
    rd_state_e             rstate_q, rstate_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [15:0]           wcount_q, wcount_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

    logic                  aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [SW-1:0]         cur_strb;
    logic [DATA_WIDTH:0]   sum_w;
    logic [DATA_WIDTH-1:0] status_w;
    logic                  unused_wstrb_msb;

    assign unused_wstrb_msb = s_axi_wstrb[SW];
    assign aw_hs    = s_axi_awvalid && awready_q;
    assign w_hs     = s_axi_wvalid && wready_q;
    assign cur_addr = aw_got_q ? awaddr_q : s_axi_awaddr;
    assign cur_data = w_got_q ? wdata_q : s_axi_wdata;
    assign cur_strb = w_got_q ? wstrb_q : s_axi_wstrb[SW-1:0];
    assign sum_w    = {1'b0, op_a_q} + {1'b0, op_b_q};

    always_comb begin
        status_w        = '0;
        status_w[0]     = sum_w[DATA_WIDTH];
        status_w[31:16] = wcount_q;
    end

    always_comb begin
        wstate_d  = wstate_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wcount_d  = wcount_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_axi_awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axi_wdata;
                    wstrb_d = s_axi_wstrb[SW-1:0];
                end
                awready_d = !aw_got_d;
                wready_d  = !w_got_d;
                if (aw_got_d && w_got_d) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    wstate_d  = W_RESP;
                    bresp_d   = OKAY;
                    wcount_d  = wcount_q + 16'd1;
                    case (decode(cur_addr))
                        SEL_OP_A: op_a_d = DATA_WIDTH'(apply_wstrb(MAX_DW'(op_a_q),
                                               MAX_DW'(cur_data), MAX_SW'(cur_strb)));
                        SEL_OP_B: op_b_d = DATA_WIDTH'(apply_wstrb(MAX_DW'(op_b_q),
                                               MAX_DW'(cur_data), MAX_SW'(cur_strb)));
                        default: begin
                            bresp_d  = SLVERR;
                            wcount_d = wcount_q;
                        end
                    endcase
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read data is sampled from the pre-commit register values on the AR edge.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = R_DATA;
                    rresp_d   = OKAY;
                    case (decode(s_axi_araddr))
                        SEL_OP_A:   rdata_d = op_a_q;
                        SEL_OP_B:   rdata_d = op_b_q;
                        SEL_RESULT: rdata_d = sum_w[DATA_WIDTH-1:0];
                        SEL_STATUS: rdata_d = status_w;
                        default: begin
                            rdata_d = '0;
                            rresp_d = SLVERR;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wcount_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wcount_q  <= wcount_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_adder_slave.sv
// Bench for two adder-slave instances (BASE_ADDR 0 and 16): directed writes/reads with
// expected responses queued at issue time and checked by channel monitors on handshake.
module tb_axi_lite_adder_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] awaddr [2];
    logic       awvalid [2];
    logic       awready [2];
    logic [31:0] wdata [2];
    logic [4:0] wstrb [2];
    logic       wvalid [2];
    logic       wready [2];
    logic [2:0] bresp [2];
    logic       bvalid [2];
    logic       bready [2];
    logic [7:0] araddr [2];
    logic       arvalid [2];
    logic       arready [2];
    logic [31:0] rdata [2];
    logic [2:0] rresp [2];
    logic       rvalid [2];
    logic       rready [2];

    int nvec = 0;
    int nfail = 0;
    logic [2:0]  eb0[$], eb1[$];
    logic [34:0] er0[$], er1[$];

    always #5 clk = ~clk;

    axi_lite_adder_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(0)) dut0 (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr[0]), .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
        .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]),
        .s_axi_wready(wready[0]), .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]),
        .s_axi_bready(bready[0]), .s_axi_araddr(araddr[0]), .s_axi_arvalid(arvalid[0]),
        .s_axi_arready(arready[0]), .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]),
        .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0]));

    axi_lite_adder_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(16)) dut1 (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr[1]), .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
        .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]),
        .s_axi_wready(wready[1]), .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]),
        .s_axi_bready(bready[1]), .s_axi_araddr(araddr[1]), .s_axi_arvalid(arvalid[1]),
        .s_axi_arready(arready[1]), .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]),
        .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitors: compare every completed B/R handshake against the queued expectation.
    always @(negedge clk) begin
        if (bvalid[0] && bready[0]) begin
            if (eb0.size() == 0) fail_now("b0_unexpected");
            else check("b0_bresp", 64'(bresp[0]), 64'(eb0.pop_front()));
        end
        if (bvalid[1] && bready[1]) begin
            if (eb1.size() == 0) fail_now("b1_unexpected");
            else check("b1_bresp", 64'(bresp[1]), 64'(eb1.pop_front()));
        end
        if (rvalid[0] && rready[0]) begin
            if (er0.size() == 0) fail_now("r0_unexpected");
            else check("r0_resp_data", 64'({rresp[0], rdata[0]}), 64'(er0.pop_front()));
        end
        if (rvalid[1] && rready[1]) begin
            if (er1.size() == 0) fail_now("r1_unexpected");
            else check("r1_resp_data", 64'({rresp[1], rdata[1]}), 64'(er1.pop_front()));
        end
    end

    task automatic drain(input int inst, input bit is_read);
        int n;
        for (n = 0; n < 50; n++) begin
            if (inst == 0 && !is_read && eb0.size() == 0) break;
            if (inst == 1 && !is_read && eb1.size() == 0) break;
            if (inst == 0 && is_read && er0.size() == 0) break;
            if (inst == 1 && is_read && er1.size() == 0) break;
            @(posedge clk); #1;
        end
        if (n == 50) fail_now(is_read ? "r_drain_timeout" : "b_drain_timeout");
    endtask

    // w_lead > 0: W presented that many cycles before AW; < 0: AW leads.
    task automatic do_write(input int inst, input logic [7:0] addr, input logic [31:0] data,
                            input logic [4:0] strb, input int w_lead, input logic [2:0] exp,
                            input bit wait_resp);
        bit aw_done, w_done;
        int aw_start, w_start, t;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        if (inst == 0) eb0.push_back(exp); else eb1.push_back(exp);
        aw_done = 0;
        w_done  = 0;
        for (t = 0; t < 50 && !(aw_done && w_done); t++) begin
            if (!aw_done && t >= aw_start) begin awaddr[inst] = addr; awvalid[inst] = 1'b1; end
            if (!w_done && t >= w_start) begin
                wdata[inst] = data; wstrb[inst] = strb; wvalid[inst] = 1'b1;
            end
            @(negedge clk);
            if (awvalid[inst] && awready[inst]) aw_done = 1;
            if (wvalid[inst] && wready[inst]) w_done = 1;
            @(posedge clk); #1;
            if (aw_done) awvalid[inst] = 1'b0;
            if (w_done) wvalid[inst] = 1'b0;
        end
        if (!(aw_done && w_done)) fail_now("write_accept_timeout");
        check("bvalid_after_commit", 64'(bvalid[inst]), 64'd1);
        if (wait_resp) drain(inst, 0);
    endtask

    task automatic do_read(input int inst, input logic [7:0] addr, input logic [31:0] exp_data,
                           input logic [2:0] exp_resp, input bit wait_resp);
        bit done;
        int t;
        if (inst == 0) er0.push_back({exp_resp, exp_data}); else er1.push_back({exp_resp, exp_data});
        done = 0;
        araddr[inst]  = addr;
        arvalid[inst] = 1'b1;
        for (t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (arready[inst]) done = 1;
            @(posedge clk); #1;
        end
        arvalid[inst] = 1'b0;
        if (!done) fail_now("read_accept_timeout");
        check("rvalid_after_ar", 64'(rvalid[inst]), 64'd1);
        if (wait_resp) drain(inst, 1);
    endtask

    task automatic check_all_zero(input int inst);
        check("rst_awready", 64'(awready[inst]), 64'd0);
        check("rst_wready",  64'(wready[inst]),  64'd0);
        check("rst_bvalid",  64'(bvalid[inst]),  64'd0);
        check("rst_bresp",   64'(bresp[inst]),   64'd0);
        check("rst_arready", 64'(arready[inst]), 64'd0);
        check("rst_rvalid",  64'(rvalid[inst]),  64'd0);
        check("rst_rdata",   64'(rdata[inst]),   64'd0);
        check("rst_rresp",   64'(rresp[inst]),   64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awvalid[i] = 0; wdata[i] = '0; wstrb[i] = '0; wvalid[i] = 0;
            bready[i] = 1; araddr[i] = '0; arvalid[i] = 0; rready[i] = 1;
        end
        #2;
        check_all_zero(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_awready", 64'(awready[0]), 64'd1);
        check("idle_wready",  64'(wready[0]),  64'd1);
        check("idle_arready", 64'(arready[0]), 64'd1);

        // Same-cycle AW/W, W-leads, error write, unmapped read.
        do_write(0, 8'h00, 32'h0000_0005, 5'h0F, 0, 3'd0, 1);
        do_read (0, 8'h00, 32'h0000_0005, 3'd0, 1);
        do_write(0, 8'h04, 32'hFFFF_FFFF, 5'h0F, 2, 3'd0, 1);
        do_read (0, 8'h08, 32'h0000_0004, 3'd0, 1);
        do_read (0, 8'h0C, 32'h0002_0001, 3'd0, 1);
        do_write(0, 8'h08, 32'h0000_1234, 5'h0F, 0, 3'd2, 1);
        do_read (0, 8'h08, 32'h0000_0004, 3'd0, 1);
        do_read (0, 8'h0C, 32'h0002_0001, 3'd0, 1);
        do_read (0, 8'h20, 32'h0000_0000, 3'd2, 1);
        do_write(0, 8'h10, 32'h0000_0099, 5'h0F, 0, 3'd2, 1);

        // Partial strobes, AW-leads with an all-zero strobe (counted, no data change).
        do_write(0, 8'h00, 32'h1122_3344, 5'h0F, 0, 3'd0, 1);
        do_write(0, 8'h00, 32'hAABB_CCDD, 5'h05, 0, 3'd0, 1);
        do_read (0, 8'h00, 32'h11BB_33DD, 3'd0, 1);
        do_write(0, 8'h04, 32'h0000_0001, 5'h00, -1, 3'd0, 1);
        do_read (0, 8'h04, 32'hFFFF_FFFF, 3'd0, 1);
        do_read (0, 8'h08, 32'h11BB_33DC, 3'd0, 1);
        do_read (0, 8'h0C, 32'h0005_0001, 3'd0, 1);

        // Backpressure on B then R.
        bready[0] = 1'b0;
        do_write(0, 8'h04, 32'h0000_0002, 5'h0F, 0, 3'd0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid",  64'(bvalid[0]),  64'd1);
            check("hold_bresp",   64'(bresp[0]),   64'd0);
            check("hold_awready", 64'(awready[0]), 64'd0);
            check("hold_wready",  64'(wready[0]),  64'd0);
        end
        @(posedge clk); #1 bready[0] = 1'b1;
        drain(0, 0);
        rready[0] = 1'b0;
        do_read(0, 8'h08, 32'h11BB_33DF, 3'd0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rvalid",  64'(rvalid[0]),  64'd1);
            check("hold_rdata",   64'(rdata[0]),   64'h11BB_33DF);
            check("hold_arready", 64'(arready[0]), 64'd0);
        end
        @(posedge clk); #1 rready[0] = 1'b1;
        drain(0, 1);

        // Asynchronous reset with both responses pending; they must be dropped.
        bready[0] = 1'b0;
        rready[0] = 1'b0;
        do_write(0, 8'h00, 32'h0000_0007, 5'h0F, 0, 3'd0, 0);
        do_read (0, 8'h00, 32'h11BB_33DD, 3'd0, 0);
        check("pre_rst_bvalid", 64'(bvalid[0]), 64'd1);
        check("pre_rst_rvalid", 64'(rvalid[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero(0);
        eb0.delete();
        er0.delete();
        bready[0] = 1'b1;
        rready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(0, 8'h00, 32'h0000_0000, 3'd0, 1);
        do_read(0, 8'h0C, 32'h0000_0000, 3'd0, 1);

        // Instance at BASE_ADDR 16.
        do_write(1, 8'h10, 32'h0000_0003, 5'h0F, 0, 3'd0, 1);
        do_write(1, 8'h14, 32'h0000_0004, 5'h0F, 1, 3'd0, 1);
        do_read (1, 8'h18, 32'h0000_0007, 3'd0, 1);
        do_read (1, 8'h08, 32'h0000_0000, 3'd2, 1);
        do_write(1, 8'h04, 32'h0000_00FF, 5'h0F, 0, 3'd2, 1);
        do_read (1, 8'h1C, 32'h0002_0000, 3'd0, 1);
        do_read (1, 8'h10, 32'h0000_0003, 3'd0, 1);

        repeat (3) @(posedge clk);
        check("eb0_left", 64'(eb0.size()), 64'd0);
        check("eb1_left", 64'(eb1.size()), 64'd0);
        check("er0_left", 64'(er0.size()), 64'd0);
        check("er1_left", 64'(er1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
